// File: rtl/cnn_window_gen_if.sv
// Pixel-in / window-out handshake bundle for cnn_window_gen.
// slave: the window generator; master: the pixel producer / window consumer.
interface cnn_window_gen_if #(
    parameter int unsigned IMG_W = 28,
    parameter int unsigned K     = 5,
    parameter int unsigned PW    = 8,
    parameter int unsigned XY_W  = 5
);
    logic                PIX_VALID;
    logic [PW-1:0]       PIX_DATA;
    logic                PIX_READY;
    logic                WIN_VALID;
    logic                WIN_READY;
    logic [XY_W-1:0]     X;
    logic [XY_W-1:0]     Y;
    logic [K*K*PW-1:0]   IMGIN;
    logic                WIN_FIRST;
    logic                WIN_LAST;
    logic                FRAME_DONE;

    modport slave (
        input  PIX_VALID, PIX_DATA, WIN_READY,
        output PIX_READY, WIN_VALID, X, Y, IMGIN, WIN_FIRST, WIN_LAST, FRAME_DONE
    );

    modport master (
        output PIX_VALID, PIX_DATA, WIN_READY,
        input  PIX_READY, WIN_VALID, X, Y, IMGIN, WIN_FIRST, WIN_LAST, FRAME_DONE
    );
endinterface

// File: rtl/cnn_window_gen.sv
// Sliding-window generator: loads one IMG_W x IMG_W frame from a raster pixel
// stream, then emits every K x K window with its top-left (X, Y) coordinates.
// Optional macro CNN_WINGEN_BINARIZE_EN: store pixels as all-ones / zero
// depending on their MSB instead of unmodified.
module cnn_window_gen #(
    parameter int unsigned IMG_W = 28,
    parameter int unsigned K     = 5,
    parameter int unsigned PW    = 8,
    parameter int unsigned XY_W  = 5
) (
    input  logic              CLK,
    input  logic              RST,
    cnn_window_gen_if.slave   win_if
);
    localparam int unsigned NPix  = IMG_W * IMG_W;
    localparam int unsigned AddrW = $clog2(NPix);
    localparam int unsigned RcW   = $clog2(IMG_W);
    localparam logic [RcW-1:0]  LastRc = RcW'(IMG_W - 1);
    localparam logic [XY_W-1:0] LastXy = XY_W'(IMG_W - K);

    typedef enum logic [1:0] {StIdle, StLoad, StScan} state_e;

    state_e          state_q, state_d;
    logic [RcW-1:0]  row_q, row_d, col_q, col_d;
    logic [XY_W-1:0] x_q, x_d, y_q, y_d;
    logic            frame_done_q, frame_done_d;

    logic [PW-1:0]   mem_q [NPix];
    logic [PW-1:0]   wr_data;
    logic [AddrW-1:0] wr_addr;
    logic            pix_hs, win_hs;
    logic [K*K*PW-1:0] imgin;

    function automatic logic [AddrW-1:0] win_addr(input logic [XY_W-1:0] x,
                                                  input logic [XY_W-1:0] y,
                                                  input int unsigned i,
                                                  input int unsigned j);
        return AddrW'((32'(x) + i) * IMG_W + 32'(y) + j);
    endfunction

    assign pix_hs  = (state_q == StLoad) && win_if.PIX_VALID;
    assign win_hs  = (state_q == StScan) && win_if.WIN_READY;
    assign wr_addr = AddrW'(32'(row_q) * IMG_W + 32'(col_q));

`ifdef CNN_WINGEN_BINARIZE_EN
    assign wr_data = (win_if.PIX_DATA >= PW'(1 << (PW - 1))) ? '1 : '0;
`else
    assign wr_data = win_if.PIX_DATA;
`endif

    // Next-state: raster write pointer during load, window pointer during scan.
    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        x_d          = x_q;
        y_d          = y_q;
        frame_done_d = 1'b0;
        unique case (state_q)
            StIdle: state_d = StLoad;
            StLoad: begin
                if (pix_hs) begin
                    if (col_q == LastRc) begin
                        col_d = '0;
                        if (row_q == LastRc) begin
                            row_d   = '0;
                            state_d = StScan;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            StScan: begin
                if (win_hs) begin
                    if (y_q == LastXy) begin
                        y_d = '0;
                        if (x_q == LastXy) begin
                            x_d          = '0;
                            state_d      = StLoad;
                            frame_done_d = 1'b1;
                        end else begin
                            x_d = x_q + 1'b1;
                        end
                    end else begin
                        y_d = y_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and pointer registers; a reset drops any partial frame silently.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= StIdle;
            row_q        <= '0;
            col_q        <= '0;
            x_q          <= '0;
            y_q          <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            x_q          <= x_d;
            y_q          <= y_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Frame buffer write; contents need no reset.
    always_ff @(posedge CLK) begin
        if (pix_hs) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Window decode straight from the buffer, so it holds while X/Y hold.
    always_comb begin
        imgin = '0;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                imgin[(i*K+j)*PW +: PW] = mem_q[win_addr(x_q, y_q, i, j)];
            end
        end
    end

    assign win_if.PIX_READY  = (state_q == StLoad);
    assign win_if.WIN_VALID  = (state_q == StScan);
    assign win_if.X          = x_q;
    assign win_if.Y          = y_q;
    assign win_if.IMGIN      = imgin;
    assign win_if.WIN_FIRST  = (x_q == '0) && (y_q == '0);
    assign win_if.WIN_LAST   = (x_q == LastXy) && (y_q == LastXy);
    assign win_if.FRAME_DONE = frame_done_q;
endmodule

// File: tb/tb_cnn_window_gen.sv
// Directed bench for cnn_window_gen: frame load, full scan, backpressure,
// gapped load, mid-scan reset and the stored-pixel transform.
module tb_cnn_window_gen;
    localparam int unsigned IMG_W = 28;
    localparam int unsigned K     = 5;
    localparam int unsigned PW    = 8;
    localparam int unsigned XY_W  = 5;
    localparam int NPIX = 784;
    localparam int NWIN = 576;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cnn_window_gen_if #(.IMG_W(IMG_W), .K(K), .PW(PW), .XY_W(XY_W)) dif ();

    cnn_window_gen #(.IMG_W(IMG_W), .K(K), .PW(PW), .XY_W(XY_W)) dut (
        .CLK    (clk),
        .RST    (rst),
        .win_if (dif)
    );

    typedef struct {
        int n;
        int x;
        int y;
        int b0;
        int b24;
        int first;
        int last;
    } vec_t;

    vec_t vecs[7];
    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] frame [NPIX];
    logic [4:0] sx [NWIN];
    logic [4:0] sy [NWIN];
    logic [7:0] sb0 [NWIN];
    logic [7:0] sb24 [NWIN];
    logic       sf [NWIN];
    logic       sl [NWIN];
    int scan_n, scan_cyc, scan_fd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int bin(input int v);
`ifdef CNN_WINGEN_BINARIZE_EN
        return (v >= 128) ? 255 : 0;
`else
        return v;
`endif
    endfunction

    function automatic logic [7:0] win_byte(input int k);
        logic [K*K*PW-1:0] w;
        w = dif.IMGIN;
        return w[k*8 +: 8];
    endfunction

    // Stream the frame until a window appears; called and returns on a negedge.
    task automatic load_frame(input bit gaps);
        int  hs = 0;
        int  cyc = 0;
        bit  ph = 1'b1;
        bit  v, hsk;
        while (!dif.WIN_VALID && cyc < 5000) begin
            v = gaps ? ph : 1'b1;
            ph = ~ph;
            dif.PIX_VALID = v;
            dif.PIX_DATA  = v ? frame[hs % NPIX] : 8'hAA;
            hsk = v && dif.PIX_READY;
            @(posedge clk);
            if (hsk) hs++;
            @(negedge clk);
            cyc++;
        end
        dif.PIX_VALID = 1'b0;
        check("pixel handshakes", hs, NPIX);
        check("pix_ready low in scan", dif.PIX_READY, 0);
    endtask

    // Record windows until NWIN handshakes; optional stall or reset at a window.
    task automatic scan(input int stall_at, input int rst_at);
        int n = 0;
        int cyc = 0;
        int fd = 0;
        logic [K*K*PW-1:0] held;
        dif.WIN_READY = 1'b1;
        while (n < NWIN && cyc < 3000) begin
            if (cyc != 0) @(negedge clk);
            cyc++;
            if (dif.FRAME_DONE) fd++;
            if (dif.WIN_VALID) begin
                sx[n]   = dif.X;
                sy[n]   = dif.Y;
                sb0[n]  = win_byte(0);
                sb24[n] = win_byte(24);
                sf[n]   = dif.WIN_FIRST;
                sl[n]   = dif.WIN_LAST;
                if (n == stall_at) begin
                    held = dif.IMGIN;
                    dif.WIN_READY = 1'b0;
                    for (int k = 0; k < 3; k++) begin
                        @(negedge clk);
                        check("stall x", dif.X, sx[n]);
                        check("stall y", dif.Y, sy[n]);
                        check("stall imgin", dif.IMGIN === held, 1);
                        check("stall valid", dif.WIN_VALID, 1);
                    end
                    dif.WIN_READY = 1'b1;
                end
                if (n == rst_at) begin
                    rst = 1'b1;
                    scan_n = n;
                    return;
                end
                n++;
            end
        end
        scan_n   = n;
        scan_cyc = cyc;
        scan_fd  = fd;
    endtask

    task automatic check_table(input string tag);
        for (int t = 0; t < 7; t++) begin
            int n;
            n = vecs[t].n;
            check({tag, " x"},     sx[n],   vecs[t].x);
            check({tag, " y"},     sy[n],   vecs[t].y);
            check({tag, " byte0"}, sb0[n],  bin(vecs[t].b0));
            check({tag, " byte24"}, sb24[n], bin(vecs[t].b24));
            check({tag, " first"}, sf[n],   vecs[t].first);
            check({tag, " last"},  sl[n],   vecs[t].last);
        end
    endtask

    task automatic full_scan_and_done(input string tag);
        scan(-1, -1);
        check({tag, " window count"}, scan_n, NWIN);
        check({tag, " scan cycles"}, scan_cyc, NWIN);
        check({tag, " early frame_done"}, scan_fd, 0);
        @(negedge clk);
        check({tag, " frame_done pulse"}, dif.FRAME_DONE, 1);
        check({tag, " pix_ready after scan"}, dif.PIX_READY, 1);
        check({tag, " win_valid after scan"}, dif.WIN_VALID, 0);
        @(negedge clk);
        check({tag, " frame_done one cycle"}, dif.FRAME_DONE, 0);
        check_table(tag);
    endtask

    initial begin
        vecs[0] = '{n: 0,   x: 0,  y: 0,  b0: 0,   b24: 116, first: 1, last: 0};
        vecs[1] = '{n: 1,   x: 0,  y: 1,  b0: 1,   b24: 117, first: 0, last: 0};
        vecs[2] = '{n: 24,  x: 1,  y: 0,  b0: 28,  b24: 144, first: 0, last: 0};
        vecs[3] = '{n: 53,  x: 2,  y: 5,  b0: 61,  b24: 177, first: 0, last: 0};
        vecs[4] = '{n: 100, x: 4,  y: 4,  b0: 116, b24: 232, first: 0, last: 0};
        vecs[5] = '{n: 250, x: 10, y: 10, b0: 34,  b24: 150, first: 0, last: 0};
        vecs[6] = '{n: 575, x: 23, y: 23, b0: 155, b24: 15,  first: 0, last: 1};
        for (int a = 0; a < NPIX; a++) frame[a] = 8'(a % 256);

        rst = 1'b1;
        dif.PIX_VALID = 1'b0;
        dif.PIX_DATA  = '0;
        dif.WIN_READY = 1'b0;
        repeat (3) @(negedge clk);
        check("reset pix_ready", dif.PIX_READY, 0);
        check("reset win_valid", dif.WIN_VALID, 0);
        check("reset frame_done", dif.FRAME_DONE, 0);
        check("reset x", dif.X, 0);
        check("reset y", dif.Y, 0);
        rst = 1'b0;

        // Gap-free load, then a full scan with WIN_READY held high.
        dif.WIN_READY = 1'b1;
        load_frame(1'b0);
        check("first win x", dif.X, 0);
        check("first win y", dif.Y, 0);
        check("first win flag", dif.WIN_FIRST, 1);
        check("first win byte4", win_byte(4), bin(4));
        check("first win byte5", win_byte(5), bin(28));
        full_scan_and_done("run1");

        // Backpressure at window (2,5), next window after release is (2,6).
        load_frame(1'b0);
        scan(53, -1);
        check("stall count", scan_n, NWIN);
        check("after stall x", sx[54], 2);
        check("after stall y", sy[54], 6);
        @(negedge clk);
        check("stall run frame_done", dif.FRAME_DONE, 1);
        @(negedge clk);
        check_table("stall");

        // Gapped load must store only handshaken pixels.
        load_frame(1'b1);
        check("gap win0 byte4", win_byte(4), bin(4));
        check("gap win0 byte5", win_byte(5), bin(28));
        full_scan_and_done("gap");

        // Reset in the middle of scanning window (10,10).
        load_frame(1'b0);
        scan(-1, 250);
        check("reset point x", sx[250], 10);
        check("reset point y", sy[250], 10);
        @(negedge clk);
        rst = 1'b0;
        check("post-rst win_valid", dif.WIN_VALID, 0);
        check("post-rst x", dif.X, 0);
        check("post-rst y", dif.Y, 0);
        check("post-rst frame_done", dif.FRAME_DONE, 0);
        check("post-rst pix_ready idle", dif.PIX_READY, 0);
        @(negedge clk);
        check("post-rst pix_ready load", dif.PIX_READY, 1);
        check("post-rst no frame_done", dif.FRAME_DONE, 0);
        load_frame(1'b0);
        full_scan_and_done("fresh");

        // Stored-pixel transform on the values 127, 128, 200.
        frame[0] = 8'd127;
        frame[1] = 8'd128;
        frame[2] = 8'd200;
        load_frame(1'b0);
`ifdef CNN_WINGEN_BINARIZE_EN
        check("bin 127", win_byte(0), 0);
        check("bin 128", win_byte(1), 255);
        check("bin 200", win_byte(2), 255);
`else
        check("raw 127", win_byte(0), 127);
        check("raw 128", win_byte(1), 128);
        check("raw 200", win_byte(2), 200);
`endif
        scan(-1, -1);
        check("last frame count", scan_n, NWIN);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
